// File: rtl/axi_write_master.sv
// AXI3 write initiator: latches one burst command, issues AW, streams W beats, then collects B.
// Define WMASTER_BTIMEOUT_EN to abandon the response wait after BTIMEOUT cycles (DECERR).
module axi_write_master #(
    parameter int buswidth = 32,
    parameter int BTIMEOUT = 256
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [31:0]           cmd_addr,
    input  logic [3:0]            cmd_len,
    input  logic [1:0]            cmd_burst,
    input  logic [3:0]            cmd_id,
    input  logic [buswidth-1:0]   wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  done,
    output logic [1:0]            done_resp,
    output logic [3:0]            AWID,
    output logic [31:0]           AWADDR,
    output logic [3:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic [1:0]            AWBURST,
    output logic [1:0]            AWLOCK,
    output logic [3:0]            AWCACHE,
    output logic [2:0]            AWPROT,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [3:0]            WID,
    output logic [buswidth-1:0]   WDATA,
    output logic [buswidth/8-1:0] WSTRB,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [3:0]            BID,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  id_q;
    logic [31:0] addr_q;
    logic [3:0]  len_q;
    logic [1:0]  burst_q;
    logic [3:0]  beat, beat_next;
    logic        done_next;
    logic [1:0]  resp_next;
    logic        timed_out;

    // Handshake-facing outputs decode straight from state so an async reset drops them at once.
    assign cmd_ready = (state == IDLE);
    assign AWVALID   = (state == ADDR);
    assign WVALID    = (state == DATA) && wr_valid;
    assign wr_ready  = (state == DATA) && WREADY;
    assign WLAST     = (state == DATA) && (beat == len_q);
    assign BREADY    = (state == RESP);
    assign WDATA     = wr_data;
    assign WSTRB     = '1;
    assign WID       = id_q;
    assign AWID      = id_q;
    assign AWADDR    = addr_q;
    assign AWLEN     = len_q;
    assign AWBURST   = burst_q;
    assign AWSIZE    = 3'($clog2(buswidth / 8));
    assign AWLOCK    = '0;
    assign AWCACHE   = '0;
    assign AWPROT    = '0;

`ifdef WMASTER_BTIMEOUT_EN
    localparam int TW = $clog2(BTIMEOUT + 1);
    logic [TW-1:0] wait_cnt;

    // wait_cnt equals the number of RESP cycles already spent without BVALID.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wait_cnt <= '0;
        end else if (state == RESP && state_next == RESP) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign timed_out = (wait_cnt == TW'(BTIMEOUT - 1));
`else
    logic unused_btimeout;
    assign unused_btimeout = ^32'(BTIMEOUT);
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_next = state;
        beat_next  = beat;
        done_next  = 1'b0;
        resp_next  = done_resp;
        unique case (state)
            IDLE: if (cmd_valid) state_next = ADDR;
            ADDR: if (AWREADY) state_next = DATA;
            DATA: begin
                if (wr_valid && WREADY) begin
                    if (beat == len_q) begin
                        beat_next  = '0;
                        state_next = RESP;
                    end else begin
                        beat_next = beat + 4'd1;
                    end
                end
            end
            RESP: begin
                if (BVALID) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    resp_next  = (BID != id_q) ? 2'b10 : BRESP;
                end else if (timed_out) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    resp_next  = 2'b11;
                end
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= IDLE;
            beat      <= '0;
            done      <= 1'b0;
            done_resp <= '0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            burst_q   <= '0;
        end else begin
            state     <= state_next;
            beat      <= beat_next;
            done      <= done_next;
            done_resp <= resp_next;
            if (state == IDLE && cmd_valid) begin
                id_q    <= cmd_id;
                addr_q  <= cmd_addr;
                len_q   <= cmd_len;
                burst_q <= cmd_burst;
            end
        end
    end

endmodule

// File: tb/tb_axi_write_master.sv
// Self-checking bench for axi_write_master: directed bursts plus randomized traffic against a burst-level model.
// Honours WMASTER_BTIMEOUT_EN for the response-timeout scenario.
module tb_axi_write_master;

    localparam int BW  = 32;
    localparam int BTO = 16;

    logic            ACLK, ARESETn;
    logic            cmd_valid, cmd_ready;
    logic [31:0]     cmd_addr;
    logic [3:0]      cmd_len;
    logic [1:0]      cmd_burst;
    logic [3:0]      cmd_id;
    logic [BW-1:0]   wr_data;
    logic            wr_valid, wr_ready;
    logic            done;
    logic [1:0]      done_resp;
    logic [3:0]      AWID;
    logic [31:0]     AWADDR;
    logic [3:0]      AWLEN;
    logic [2:0]      AWSIZE;
    logic [1:0]      AWBURST, AWLOCK;
    logic [3:0]      AWCACHE;
    logic [2:0]      AWPROT;
    logic            AWVALID, AWREADY;
    logic [3:0]      WID;
    logic [BW-1:0]   WDATA;
    logic [BW/8-1:0] WSTRB;
    logic            WLAST, WVALID, WREADY;
    logic [3:0]      BID;
    logic [1:0]      BRESP;
    logic            BVALID, BREADY;

    int checks = 0;
    int errors = 0;

    axi_write_master #(.buswidth(BW), .BTIMEOUT(BTO)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_burst(cmd_burst), .cmd_id(cmd_id),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .done(done), .done_resp(done_resp),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clear_inputs();
        cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_burst = '0; cmd_id = '0;
        wr_data = '0; wr_valid = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
        BVALID = 1'b0; BID = '0; BRESP = '0;
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        ARESETn = 1'b0;
        clear_inputs();
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
    endtask

    // One burst through the device, AW, W and B interfaces. The model is the burst itself:
    // a list of beats that must appear in order, and the response the device should see.
    task automatic run_burst(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] bt,
                             input logic [3:0] id, input int aw_delay, input int stall_pct,
                             input logic [3:0] bid, input logic [1:0] bresp, input bit b_never,
                             input int abort_beat);
        logic [31:0] data[$];
        logic [1:0]  exp_resp;
        int          beat = 0, aw_cycles = 0, resp_cycles = 0;
        bit          aw_done = 0, b_hs = 0, finished = 0, aborted = 0, stuck = 0;
        bit          in_data, b_prev;
        for (int i = 0; i <= int'(len); i++) data.push_back($urandom);
        exp_resp = b_never ? 2'b11 : ((bid != id) ? 2'b10 : bresp);

        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_addr = addr; cmd_len = len; cmd_burst = bt; cmd_id = id;
        #1 chk("cmd_ready_idle", cmd_ready, 1);

        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            @(negedge ACLK);
            cmd_valid = (cyc < 2);
            cmd_addr = ~addr; cmd_len = ~len; cmd_burst = ~bt; cmd_id = ~id;
            AWREADY  = (aw_cycles >= aw_delay);
            WREADY   = ($urandom_range(99) >= stall_pct);
            wr_valid = (beat <= int'(len)) && ($urandom_range(99) >= stall_pct);
            wr_data  = (beat <= int'(len)) ? data[beat] : $urandom;
            BVALID   = !b_never && (beat > int'(len)) && !b_hs;
            BID = bid; BRESP = bresp;
            if (abort_beat >= 0 && aw_done && beat == abort_beat) begin
                wr_valid = 1'b1; WREADY = 1'b1; AWREADY = 1'b1; BVALID = 1'b1;
                ARESETn = 1'b0;
                #1;
                chk("rst_awvalid", AWVALID, 0);
                chk("rst_wvalid", WVALID, 0);
                chk("rst_wr_ready", wr_ready, 0);
                chk("rst_bready", BREADY, 0);
                chk("rst_done", done, 0);
                repeat (2) @(negedge ACLK);
                clear_inputs();
                ARESETn = 1'b1;
                #1 chk("rst_release_ready", cmd_ready, 1);
                chk("rst_release_awaddr", AWADDR, 0);
                for (int k = 0; k < 3; k++) begin
                    @(negedge ACLK);
                    #1 chk("rst_no_done", done, 0);
                end
                aborted  = 1;
                finished = 1;
                break;
            end
            #1;
            in_data = aw_done && (beat <= int'(len));
            b_prev  = b_hs;
            chk("cmd_ready_busy", cmd_ready, done);
            if (!aw_done) chk("no_w_before_aw", WVALID, 0);
            if (AWVALID) begin
                chk("awaddr", AWADDR, addr);
                chk("awlen", AWLEN, len);
                chk("awid", AWID, id);
                chk("awburst", AWBURST, bt);
                if (AWREADY) aw_done = 1;
                aw_cycles++;
            end
            if (in_data) begin
                chk("wvalid_pass", WVALID, wr_valid);
                chk("wr_ready_pass", wr_ready, WREADY);
            end
            if (WVALID) begin
                if (beat > int'(len)) begin
                    chk("extra_beat", beat, len);
                end else begin
                    chk("wdata", WDATA, data[beat]);
                    chk("wlast", WLAST, beat == int'(len));
                    chk("wid", WID, id);
                    if (WREADY) beat++;
                end
            end
            if (BREADY) begin
                chk("bready_after_w", beat, int'(len) + 1);
                resp_cycles++;
                if (BVALID) b_hs = 1;
            end
            if (done) begin
`ifdef WMASTER_BTIMEOUT_EN
                if (b_never) chk("timeout_cycles", resp_cycles, BTO);
                else chk("done_after_b", b_prev, 1);
`else
                chk("done_after_b", b_prev, 1);
`endif
                chk("done_resp", done_resp, exp_resp);
                finished = 1;
            end
            if (b_never && resp_cycles >= 300 && !finished) begin
                chk("bready_held", BREADY, 1);
                chk("no_done_waiting", done, 0);
                stuck    = 1;
                finished = 1;
            end
        end

        if (!finished) chk("burst_cycle_budget", 0, 1);
        else if (!aborted && !stuck) begin
            chk("beat_count", beat, int'(len) + 1);
            chk("aw_cycles", aw_cycles, aw_delay + 1);
            @(negedge ACLK);
            clear_inputs();
            #1 chk("done_one_cycle", done, 0);
            chk("done_resp_hold", done_resp, exp_resp);
            chk("idle_after", cmd_ready, 1);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        ARESETn = 1'b1;
        #2 ARESETn = 1'b0;
        wr_valid = 1'b1; WREADY = 1'b1; AWREADY = 1'b1; BVALID = 1'b1;
        #1;
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_awvalid", AWVALID, 0);
        chk("reset_wvalid", WVALID, 0);
        chk("reset_wr_ready", wr_ready, 0);
        chk("reset_bready", BREADY, 0);
        chk("reset_done", done, 0);
        chk("reset_done_resp", done_resp, 0);
        chk("reset_awaddr", AWADDR, 0);
        chk("reset_awlen", AWLEN, 0);
        chk("awsize", AWSIZE, 3'd2);
        chk("wstrb", WSTRB, 4'hF);
        chk("aw_constants", {AWLOCK, AWCACHE, AWPROT}, 0);
        repeat (2) @(negedge ACLK);
        clear_inputs();
        ARESETn = 1'b1;

        run_burst(32'h0000_1000, 4'd0, 2'b01, 4'd3, 0, 0, 4'd3, 2'b00, 0, -1);
        run_burst(32'h0000_2000, 4'd3, 2'b01, 4'd7, 3, 0, 4'd7, 2'b01, 0, -1);
        run_burst(32'h0000_3000, 4'd15, 2'b10, 4'd9, 1, 40, 4'd9, 2'b00, 0, -1);
        run_burst(32'h0000_4000, 4'd1, 2'b00, 4'd3, 0, 0, 4'd5, 2'b00, 0, -1);
        run_burst(32'h0000_5000, 4'd3, 2'b01, 4'd2, 0, 0, 4'd2, 2'b00, 0, 1);
        run_burst(32'h0000_6000, 4'd2, 2'b01, 4'd4, 0, 0, 4'd4, 2'b00, 0, -1);

        for (int n = 0; n < 10; n++) begin
            logic [3:0] rid, rbid;
            rid  = 4'($urandom);
            rbid = ($urandom_range(3) == 0) ? 4'(rid + 4'd1) : rid;
            run_burst($urandom, 4'($urandom), 2'($urandom_range(2)), rid,
                      int'($urandom_range(4)), int'($urandom_range(50)),
                      rbid, 2'($urandom), 0, -1);
        end

        run_burst(32'h0000_7000, 4'd1, 2'b01, 4'd6, 0, 0, 4'd6, 2'b00, 1, -1);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
